// File: rtl/uart_byte_transmitter.sv
// uart_byte_transmitter
//   Self-timed 8N1 transmitter. A free-running delay counter raises a trigger
//   once every MCNT_DLY+1 clocks. If the transmitter is idle at that moment,
//   it latches `data`, toggles `led` and sends the byte on `uart_tx`
//   (start bit, LSB first, stop bit). A trigger that arrives mid-frame is
//   dropped.
//
// Parameters
//   MCNT_DLY  : terminal count of the inter-frame delay counter
//   BAUD_MCNT : terminal count of the bit-period counter (bit = BAUD_MCNT+1 clk)
// Ports
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous active-high reset
//   data    : byte to send, sampled only on an accepted trigger
//   uart_tx : serial line, idle high, registered
//   led     : toggles on every accepted frame start, registered
module uart_byte_transmitter #(
    parameter int MCNT_DLY  = 49_999_999,
    parameter int BAUD_MCNT = 433
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data,
    output logic       uart_tx,
    output logic       led
);

    localparam int DLY_W  = ($clog2(MCNT_DLY + 1) > 26) ? $clog2(MCNT_DLY + 1) : 26;
    localparam int BAUD_W = ($clog2(BAUD_MCNT + 1) > 1) ? $clog2(BAUD_MCNT + 1) : 1;
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(MCNT_DLY);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_MCNT);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t            state;
    logic [DLY_W-1:0]  dly_cnt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [7:0]        hold;
    logic              trig;

    // Line level for frame slot idx: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
        logic v;
        v = 1'b1;
        if (idx == 4'd0)
            v = 1'b0;
        else if (idx <= 4'd8)
            v = b[3'(idx - 4'd1)];
        return v;
    endfunction

    assign trig = (dly_cnt == DLY_LAST);

    // Delay counter free-runs regardless of transmitter state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            dly_cnt <= '0;
        else if (trig)
            dly_cnt <= '0;
        else
            dly_cnt <= dly_cnt + 1'b1;
    end

    // Transmit FSM. uart_tx is loaded with the level of the slot being
    // entered, so the start bit appears on the same edge as the trigger.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            hold     <= '0;
            uart_tx  <= 1'b1;
            led      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    uart_tx  <= 1'b1;
                    if (trig) begin
                        hold    <= data;
                        led     <= ~led;
                        uart_tx <= frame_bit(4'd0, data);
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            // Stop bit done; triggers seen while sending are lost.
                            bit_cnt <= '0;
                            uart_tx <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            uart_tx <= frame_bit(bit_cnt + 4'd1, hold);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter. Two instances with scaled-down
// timing keep the run short while preserving every ratio that matters:
//   u_a : MCNT_DLY=199, BAUD_MCNT=7 -> trigger every 200 clk, frame 80 clk
//   u_b : MCNT_DLY=29,  BAUD_MCNT=7 -> trigger every 30 clk, frame 80 clk,
//         so only every third trigger is accepted (starts 90 clk apart).
module tb_uart_byte_transmitter;

    localparam int DLY_A = 199;
    localparam int DLY_B = 29;
    localparam int BAUD  = 7;
    localparam int BIT   = BAUD + 1;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [7:0] data_a = 8'h0F;
    logic [7:0] data_b = 8'hA5;
    logic       tx_a, led_a, tx_b, led_b;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_byte_transmitter #(.MCNT_DLY(DLY_A), .BAUD_MCNT(BAUD)) u_a (
        .sys_clk(clk), .sys_rst(rst_a), .data(data_a), .uart_tx(tx_a), .led(led_a)
    );

    uart_byte_transmitter #(.MCNT_DLY(DLY_B), .BAUD_MCNT(BAUD)) u_b (
        .sys_clk(clk), .sys_rst(rst_b), .data(data_b), .uart_tx(tx_b), .led(led_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered 1 unit after a frame's start edge. Checks the first and last
    // clock of every slot, optionally rewrites data_a during slot chg_idx,
    // and leaves 1 unit after the edge that ends the stop bit.
    task automatic frame(input bit use_b, input logic [7:0] b, input int chg_idx,
                         input logic [7:0] nd, input string tag);
        logic e;
        for (int i = 0; i < 10; i++) begin
            e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[3'(i - 1)];
            chk($sformatf("%s slot%0d first", tag, i), use_b ? tx_b : tx_a, e);
            if (i == chg_idx) data_a = nd;
            step(BIT - 1);
            chk($sformatf("%s slot%0d last", tag, i), use_b ? tx_b : tx_a, e);
            step(1);
        end
        chk($sformatf("%s idle after stop", tag), use_b ? tx_b : tx_a, 1'b1);
    endtask

    initial begin
        // Reset values while held.
        step(3);
        chk("rst tx", tx_a, 1'b1);
        chk("rst led", led_a, 1'b0);

        // Frame 0x0F: start exactly at edge DLY_A+1 after release.
        @(negedge clk) rst_a = 1'b0;
        step(DLY_A);
        chk("f0 pre tx", tx_a, 1'b1);
        chk("f0 pre led", led_a, 1'b0);
        step(1);
        chk("f0 led", led_a, 1'b1);
        frame(1'b0, 8'h0F, -1, 8'h00, "f0");

        // Frame 0xF0, data changed between frames; 200 clk start-to-start.
        data_a = 8'hF0;
        step(DLY_A + 1 - 10 * BIT - 1);
        chk("f1 pre tx", tx_a, 1'b1);
        chk("f1 pre led", led_a, 1'b1);
        step(1);
        chk("f1 led", led_a, 1'b0);
        frame(1'b0, 8'hF0, -1, 8'h00, "f1");

        // Data switched 0x0F -> 0xF0 during the frame: frame keeps 0x0F.
        data_a = 8'h0F;
        step(DLY_A + 1 - 10 * BIT - 1);
        chk("f2 pre tx", tx_a, 1'b1);
        step(1);
        chk("f2 led", led_a, 1'b1);
        frame(1'b0, 8'h0F, 4, 8'hF0, "f2");
        step(DLY_A + 1 - 10 * BIT);
        chk("f3 led", led_a, 1'b0);
        frame(1'b0, 8'hF0, -1, 8'h00, "f3");

        // Reset during data bit 3 (slot 4, value 0 for 0xF0).
        step(DLY_A + 1 - 10 * BIT);
        chk("f4 led", led_a, 1'b1);
        chk("f4 start", tx_a, 1'b0);
        step(4 * BIT + 3);
        chk("f4 slot4 before rst", tx_a, 1'b0);
        #2 rst_a = 1'b1;
        #1;
        chk("midrst tx async", tx_a, 1'b1);
        chk("midrst led async", led_a, 1'b0);
        step(3);
        chk("midrst tx held", tx_a, 1'b1);
        chk("midrst led held", led_a, 1'b0);
        @(negedge clk) rst_a = 1'b0;
        step(DLY_A);
        chk("f5 pre tx", tx_a, 1'b1);
        chk("f5 pre led", led_a, 1'b0);
        step(1);
        chk("f5 led", led_a, 1'b1);
        frame(1'b0, 8'hF0, -1, 8'h00, "f5");

        // Short delay: triggers at 30,60,90,120,...; frame busy 30..110,
        // so 60/90 drop and the next accepted start is edge 120.
        @(negedge clk) rst_b = 1'b0;
        step(DLY_B);
        chk("s0 pre tx", tx_b, 1'b1);
        step(1);
        chk("s0 led", led_b, 1'b1);
        frame(1'b1, 8'hA5, -1, 8'h00, "s0");
        data_b = 8'h3C;
        step(9);
        chk("s1 pre tx", tx_b, 1'b1);
        chk("s1 pre led", led_b, 1'b1);
        step(1);
        chk("s1 led", led_b, 1'b0);
        frame(1'b1, 8'h3C, -1, 8'h00, "s1");
        step(9);
        chk("s2 pre tx", tx_b, 1'b1);
        chk("s2 pre led", led_b, 1'b0);
        step(1);
        chk("s2 start", tx_b, 1'b0);
        chk("s2 led", led_b, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
